// File: rtl/tt_gate_pkg.sv
// Shared types and helpers for the programmable truth-table gate.
// Tables use the hex-name convention: the table MSB is the output for row 0.
package tt_gate_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_e;

  localparam int MAX_N_IN = 6;
  localparam int MAX_TT_W = 64;

  function automatic int tt_width(input int n_in);
    return 32'sd1 << n_in;
  endfunction

  // Row r lives at bit (tt_w-1-r), so row 0 is the most significant table bit.
  function automatic logic tt_row_bit(input logic [MAX_TT_W-1:0] tt,
                                      input int                  tt_w,
                                      input logic [MAX_N_IN-1:0] row);
    logic [MAX_N_IN-1:0] idx;
    idx = MAX_N_IN'(tt_w - 32'sd1) - row;
    return tt[idx];
  endfunction

endpackage

// File: rtl/tt_settle_filter.sv
// Output settle filter: the candidate must disagree with the held output on
// SETTLE+1 consecutive edges before the output follows it.
module tt_settle_filter #(
  parameter int SETTLE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cand,
  output logic out
);

  localparam int CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE);

  logic [CNT_W-1:0] cnt_r;
  logic             out_r;

  // Disagreement run counter and held output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      out_r <= 1'b0;
    end else if (cand == out_r) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_MAX) begin
      out_r <= cand;
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign out = out_r;

endmodule

// File: rtl/tt_gate_eval.sv
// Runtime-programmable N_IN-input truth-table gate with a serial table loader
// and a settle-filtered registered output.
module tt_gate_eval
  import tt_gate_pkg::*;
#(
  parameter int                     N_IN     = 3,
  parameter int                     SETTLE   = 4,
  parameter logic [(1<<N_IN)-1:0]   RESET_TT = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] in,
  input  logic            cfg_load,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_busy,
  output logic            cfg_done,
  output logic            out
);

  localparam int TT_W = tt_width(N_IN);
  localparam logic [N_IN-1:0] LAST_BIT = {N_IN{1'b1}};

  state_e          state_r, state_s;
  logic [TT_W-1:0] shadow_r, shadow_s;
  logic [TT_W-1:0] active_tt_r;
  logic [N_IN-1:0] bcnt_r, bcnt_s;
  logic [N_IN-1:0] in_q_r;
  logic            commit_s;
  logic            cand_s;
  logic            cfg_busy_r;
  logic            cfg_done_r;

  // Loader next-state: a cfg_load always restarts, even on the final bit.
  always_comb begin
    state_s  = state_r;
    shadow_s = shadow_r;
    bcnt_s   = bcnt_r;
    commit_s = 1'b0;
    case (state_r)
      RUN: begin
        if (cfg_load) begin
          state_s  = LOAD;
          shadow_s = '0;
          bcnt_s   = '0;
        end else begin
          state_s  = RUN;
        end
      end
      LOAD: begin
        if (cfg_load) begin
          shadow_s = '0;
          bcnt_s   = '0;
        end else if (cfg_valid) begin
          shadow_s = {shadow_r[TT_W-2:0], cfg_bit};
          if (bcnt_r == LAST_BIT) begin
            commit_s = 1'b1;
            state_s  = RUN;
            bcnt_s   = '0;
          end else begin
            bcnt_s   = bcnt_r + 1'b1;
          end
        end else begin
          state_s  = LOAD;
        end
      end
      default: begin
        state_s  = RUN;
        shadow_s = '0;
        bcnt_s   = '0;
      end
    endcase
  end

  // Loader state, tables, input register and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      shadow_r    <= '0;
      bcnt_r      <= '0;
      active_tt_r <= RESET_TT;
      in_q_r      <= '0;
      cfg_busy_r  <= 1'b0;
      cfg_done_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      shadow_r   <= shadow_s;
      bcnt_r     <= bcnt_s;
      in_q_r     <= in;
      cfg_busy_r <= (state_s == LOAD);
      cfg_done_r <= commit_s;
      if (commit_s) begin
        active_tt_r <= shadow_s;
      end
    end
  end

  assign cand_s = tt_row_bit(MAX_TT_W'(active_tt_r), TT_W, MAX_N_IN'(in_q_r));

  tt_settle_filter #(
    .SETTLE (SETTLE)
  ) u_filter (
    .clk  (clk),
    .rst  (rst),
    .cand (cand_s),
    .out  (out)
  );

  assign cfg_busy = cfg_busy_r;
  assign cfg_done = cfg_done_r;

endmodule

// File: tb/tb_tt_gate_eval.sv
// Self-checking bench: three gate configurations, vector tables, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_tt_gate_eval;

  localparam int SB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] a_in = 3'b000;
  logic a_load = 1'b0, a_valid = 1'b0, a_bit = 1'b0;
  logic a_busy, a_done, a_out;
  logic [2:0] b_in = 3'b000;
  logic b_load = 1'b0, b_valid = 1'b0, b_bit = 1'b0;
  logic b_busy, b_done, b_out;
  logic [0:0] c_in = 1'b0;
  logic c_load = 1'b0, c_valid = 1'b0, c_bit = 1'b0;
  logic c_busy, c_done, c_out;

  tt_gate_eval #(.N_IN(3), .SETTLE(0), .RESET_TT(8'h00)) u_a (
    .clk(clk), .rst(rst), .in(a_in), .cfg_load(a_load), .cfg_valid(a_valid),
    .cfg_bit(a_bit), .cfg_busy(a_busy), .cfg_done(a_done), .out(a_out));
  tt_gate_eval #(.N_IN(3), .SETTLE(SB), .RESET_TT(8'hAA)) u_b (
    .clk(clk), .rst(rst), .in(b_in), .cfg_load(b_load), .cfg_valid(b_valid),
    .cfg_bit(b_bit), .cfg_busy(b_busy), .cfg_done(b_done), .out(b_out));
  tt_gate_eval #(.N_IN(1), .SETTLE(0), .RESET_TT(2'b00)) u_c (
    .clk(clk), .rst(rst), .in(c_in), .cfg_load(c_load), .cfg_valid(c_valid),
    .cfg_bit(c_bit), .cfg_busy(c_busy), .cfg_done(c_done), .out(c_out));

  int n_vec = 0;
  int n_err = 0;
  bit chk_b = 1'b0;

  // Reference model for instance b (SETTLE=4, reset table 0xAA).
  logic [7:0] m_tt;
  logic [2:0] m_inq;
  logic       m_out, m_busy, m_done;
  logic       bits[$];
  logic       hist[$];

  typedef struct {
    logic [2:0] in;
    logic       exp;
  } vec_t;
  vec_t vt[8];

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tt = 8'hAA; m_inq = 3'd0; m_out = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    bits.delete(); hist.delete();
  endtask

  task automatic model_step();
    logic cand, flip;
    if (rst) begin
      model_reset();
      return;
    end
    cand = m_tt[7 - int'(m_inq)];
    hist.push_back(cand);
    if (hist.size() > SB + 1) void'(hist.pop_front());
    flip = (hist.size() == SB + 1);
    foreach (hist[i]) if (hist[i] == m_out) flip = 1'b0;
    if (flip) begin
      m_out = ~m_out;
      hist.delete();
    end
    m_done = 1'b0;
    if (m_busy) begin
      if (b_load) bits.delete();
      else if (b_valid) begin
        bits.push_back(b_bit);
        if (bits.size() == 8) begin
          for (int i = 0; i < 8; i++) m_tt[7-i] = bits[i];
          m_done = 1'b1;
          m_busy = 1'b0;
          bits.delete();
        end
      end
    end else if (b_load) begin
      m_busy = 1'b1;
      bits.delete();
    end
    m_inq = b_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (chk_b) begin
      check("b_out_model", b_out, m_out);
      check("b_busy_model", b_busy, m_busy);
      check("b_done_model", b_done, m_done);
    end
  endtask

  task automatic load_a(input logic [7:0] tt, input bit do_pulse);
    int dones = 0;
    if (do_pulse) begin
      a_load = 1'b1; tick(); a_load = 1'b0;
      check("a_busy_rise", a_busy, 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      a_valid = 1'b1; a_bit = tt[7-i];
      tick();
      if (a_done) dones++;
      check("a_busy_load", a_busy, 1'(i < 7));
    end
    a_valid = 1'b0; a_bit = 1'b0;
    check("a_done_commit", a_done, 1'b1);
    tick();
    check("a_done_low", a_done, 1'b0);
    check("a_done_once", 1'(dones == 1), 1'b1);
  endtask

  task automatic apply_a(input logic [2:0] in, input logic exp, input logic prev);
    a_in = in;
    tick();
    check("a_out_hold", a_out, prev);
    tick();
    check("a_out", a_out, exp);
  endtask

  initial begin
    logic prev;
    int nv;
    vt = '{'{3'b011, 1'b1}, '{3'b111, 1'b0}, '{3'b000, 1'b0}, '{3'b100, 1'b1},
           '{3'b101, 1'b1}, '{3'b010, 1'b0}, '{3'b110, 1'b1}, '{3'b001, 1'b0}};
    model_reset();
    tick(); tick();
    check("rst_a_out", a_out, 1'b0); check("rst_a_busy", a_busy, 1'b0);
    check("rst_a_done", a_done, 1'b0); check("rst_b_out", b_out, 1'b0);
    check("rst_c_busy", c_busy, 1'b0);
    chk_b = 1'b1;
    rst = 1'b0;

    // Instance a: load 0x1E, then walk the vector table.
    load_a(8'h1E, 1'b1);
    prev = 1'b0;
    foreach (vt[i]) begin
      apply_a(vt[i].in, vt[i].exp, prev);
      prev = vt[i].exp;
    end

    // Load 0xFF with valid gaps; in=001 stays on the old table until commit+1.
    a_load = 1'b1; tick(); a_load = 1'b0;
    nv = 0;
    for (int k = 0; k < 15; k++) begin
      a_valid = 1'((k % 2) == 0); a_bit = 1'b1;
      tick();
      if (a_valid) nv++;
      check("gap_done", a_done, 1'(nv == 8));
      check("gap_busy", a_busy, 1'(nv != 8));
      check("gap_out_old", a_out, 1'b0);
    end
    a_valid = 1'b0;
    tick();
    check("gap_out_new", a_out, 1'b1);
    check("gap_done_low", a_done, 1'b0);

    // Abort a 0x00 load after 5 bits by restarting with a full 0x80 load.
    a_load = 1'b1; tick(); a_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_valid = 1'b1; a_bit = 1'b0; tick();
      check("abort_done", a_done, 1'b0);
      check("abort_out_old", a_out, 1'b1);
    end
    load_a(8'h80, 1'b1);
    prev = 1'b0;
    for (int r = 0; r < 8; r++) begin
      apply_a(3'(r), 1'(r == 0), prev);
      prev = 1'(r == 0);
    end

    // cfg_load coinciding with the final valid bit wins; no commit.
    a_load = 1'b1; tick(); a_load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a_valid = 1'b1; a_bit = 1'b1; tick();
    end
    a_valid = 1'b1; a_bit = 1'b1; a_load = 1'b1;
    tick();
    a_valid = 1'b0; a_load = 1'b0;
    check("lw_done", a_done, 1'b0);
    check("lw_busy", a_busy, 1'b1);
    tick();
    check("lw_busy2", a_busy, 1'b1);
    load_a(8'h1E, 1'b0);
    apply_a(3'b100, 1'b1, 1'b0);

    // Instance c: N_IN=1 buffer, then cfg_valid in RUN is ignored.
    c_load = 1'b1; tick(); c_load = 1'b0;
    c_valid = 1'b1; c_bit = 1'b0; tick();
    c_bit = 1'b1; tick();
    c_valid = 1'b0;
    check("c_done", c_done, 1'b1);
    check("c_busy", c_busy, 1'b0);
    c_in = 1'b1; tick(); tick();
    check("c_out_1", c_out, 1'b1);
    c_in = 1'b0; tick(); tick();
    check("c_out_0", c_out, 1'b0);
    c_in = 1'b1; c_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      c_bit = 1'(i % 2); tick();
      check("c_run_busy", c_busy, 1'b0);
      check("c_run_done", c_done, 1'b0);
    end
    c_valid = 1'b0;
    check("c_run_out", c_out, 1'b1);
    c_in = 1'b0; tick(); tick();
    check("c_tbl_kept", c_out, 1'b0);

    // Instance b: load 0x1E, then glitch filtering with SETTLE=4.
    b_load = 1'b1; tick(); b_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b_valid = 1'b1; b_bit = 1'(8'h1E >> (7 - i)); tick();
    end
    b_valid = 1'b0;
    check("b_done", b_done, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    check("b_settled0", b_out, 1'b0);
    b_in = 3'b100;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 4) b_in = 3'b000;
      check("b_pulse4", b_out, 1'b0);
    end
    b_in = 3'b100;
    for (int k = 1; k <= 14; k++) begin
      tick();
      check("b_pulse6", b_out, 1'(k >= 6 && k <= 11));
      if (k == 6) b_in = 3'b000;
    end

    // Asynchronous reset in the middle of a load.
    b_in = 3'b011;
    for (int i = 0; i < 7; i++) tick();
    check("b_pre_rst_out", b_out, 1'b1);
    b_load = 1'b1; tick(); b_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_valid = 1'b1; b_bit = 1'b1; tick();
    end
    b_valid = 1'b0; b_in = 3'b000;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("arst_out", b_out, 1'b0);
    check("arst_busy", b_busy, 1'b0);
    check("arst_a_out", a_out, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("post_rst_out", b_out, 1'(k >= 5));
      check("post_rst_done", b_done, 1'b0);
    end

    // Randomized traffic on b against the model.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(3) == 0) b_in = 3'($urandom);
      b_load  = ($urandom_range(39) == 0);
      b_valid = 1'($urandom_range(1));
      b_bit   = 1'($urandom_range(1));
      tick();
    end
    b_load = 1'b0; b_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
